// File: rtl/regfile_port_arbiter.sv
// Register-file write-port arbiter: ALU writebacks normally win over a 2-entry in-order
// memory-load FIFO, with a starvation guard and a pending-destination scoreboard.
module regfile_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd_i,
  input  logic [15:0] alu_rd,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_index,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [3:0]  issue_rd,
  input  logic [3:0]  rs1_i,
  input  logic [3:0]  rs2_i,
  output logic        hazard,
  output logic        wr_en,
  output logic [3:0]  wr_index,
  output logic [15:0] wr_data,
  output logic [1:0]  fifo_count
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_FIFO
  } grant_e;

  localparam logic [1:0] STARVE_MAX = 2'd3;

  logic [1:0]  entry_valid;
  logic        head_ptr;
  logic [3:0]  entry_index [2];
  logic [15:0] entry_data  [2];
  logic [1:0]  starve_cnt;
  logic [15:0] pending;

  grant_e      grant;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        tail_ptr;
  logic        alu_eligible;
  logic [3:0]  grant_index;
  logic [15:0] grant_data;
  logic [1:0]  starve_next;
  logic [15:0] pending_next;

  assign fifo_count   = {1'b0, entry_valid[0]} + {1'b0, entry_valid[1]};
  assign fifo_empty   = (entry_valid == 2'b00);
  assign fifo_full    = (entry_valid == 2'b11);
  assign mem_ready    = !fifo_full;
  assign alu_ready    = (starve_cnt != STARVE_MAX);
  assign alu_eligible = alu_valid && alu_ready && (alu_rd_i != 4'd0);
  assign push         = mem_valid && mem_ready;
  assign pop          = (grant == GNT_FIFO);

  // An empty FIFO fills at the head slot; with one entry the new load goes behind it.
  assign tail_ptr = fifo_empty ? head_ptr : ~head_ptr;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    grant       = GNT_NONE;
    grant_index = 4'd0;
    grant_data  = 16'd0;
    if (alu_eligible) begin
      grant       = GNT_ALU;
      grant_index = alu_rd_i;
      grant_data  = alu_rd;
    end else if (!fifo_empty) begin
      grant       = GNT_FIFO;
      grant_index = entry_index[head_ptr];
      grant_data  = entry_data[head_ptr];
    end
  end

  // The counter can only reach 3 while loads wait, and at 3 the ALU is held off.
  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || (grant == GNT_FIFO)) begin
      starve_next = 2'd0;
    end else if (grant == GNT_ALU) begin
      starve_next = starve_cnt + 2'd1;
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    pending_next = pending;
    if (grant != GNT_NONE) begin
      pending_next[grant_index] = 1'b0;
    end
    if (issue_valid && (issue_rd != 4'd0)) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  assign hazard = ((rs1_i != 4'd0) && pending[rs1_i]) ||
                  ((rs2_i != 4'd0) && pending[rs2_i]);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      entry_valid <= 2'b00;
      head_ptr    <= 1'b0;
    end else begin
      if (pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= ~head_ptr;
      end
      if (push) begin
        entry_valid[tail_ptr] <= 1'b1;
      end
    end
  end

  // NOTE: the payload array is deliberately not reset; entry_valid alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_index[tail_ptr] <= mem_index;
      entry_data[tail_ptr]  <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 2'd0;
      pending    <= 16'd0;
    end else begin
      starve_cnt <= starve_next;
      pending    <= pending_next;
    end
  end

  // wr_index/wr_data only move on a grant so they hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_index <= 4'd0;
      wr_data  <= 16'd0;
    end else begin
      wr_en <= (grant != GNT_NONE);
      if (grant != GNT_NONE) begin
        wr_index <= grant_index;
        wr_data  <= grant_data;
      end
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have ports: alu_valid  input  1; alu_rd_i  input  4; alu_rd  input  16; ALU writeback request, destination and data.
REQ-004 SHALL have port: alu_ready  output  1  ALU writeback accepted this cycle when high with alu_valid.
REQ-005 SHALL have ports: mem_valid  input  1; mem_index  input  4; mem_data  input  16; mem_ready  output  1; memory-load request, valid/ready handshake.
REQ-006 SHALL have ports: issue_valid  input  1; issue_rd  input  4; marks a destination register as pending.
REQ-007 SHALL have ports: rs1_i  input  4; rs2_i  input  4; hazard  output  1; source-operand hazard query.
REQ-008 SHALL have ports: wr_en  output  1; wr_index  output  4; wr_data  output  16; registered single write port to the register file.
REQ-009 SHALL have port: fifo_count  output  2  memory-load FIFO occupancy, 0..2.

Function
REQ-010 SHALL buffer accepted memory loads in a 2-entry in-order FIFO; mem_ready = (fifo_count != 2).
REQ-011 SHALL push when mem_valid && mem_ready; push and pop in the same cycle SHALL leave fifo_count unchanged; no push while fifo_count = 2.
REQ-012 SHALL grant one writer per cycle: an eligible ALU request (alu_valid && alu_ready && alu_rd_i != 0) wins, else the FIFO head if fifo_count != 0, else no grant.
REQ-013 SHALL drop an ALU request with alu_rd_i = 0 (accepted, no write, no grant consumed); memory loads to index 0 (IR) SHALL be written normally.
REQ-014 SHALL keep a starvation counter (0..3): increment when FIFO non-empty and ALU wins; clear on any FIFO grant or when the FIFO is empty.
REQ-015 SHALL drive alu_ready = 0 while the starvation counter = 3, forcing a FIFO grant that cycle; otherwise alu_ready = 1.
REQ-016 SHALL register the granted write: wr_en/wr_index/wr_data valid on the cycle after the grant; wr_en = 0 on cycles following no grant.
REQ-017 SHALL give latency ALU accept (cycle N) -> wr_en at N+1; memory accept (cycle N) -> earliest wr_en at N+2.
REQ-018 SHALL hold wr_index/wr_data at their last value when wr_en = 0.
REQ-019 SHALL maintain pending[15:0]: issue_valid sets pending[issue_rd]; a grant to index k clears pending[k]; index 0 SHALL never be set.
REQ-020 SHALL, on simultaneous set and clear of the same index, leave the bit set.
REQ-021 SHALL compute hazard combinationally = (rs1_i != 0 && pending[rs1_i]) || (rs2_i != 0 && pending[rs2_i]).
REQ-022 SHALL not reorder memory loads; FIFO entries SHALL be written in acceptance order.

Reset
REQ-023 SHALL, while rst_n = 0: fifo_count = 0, FIFO entries invalid, pending = 0, starvation counter = 0, wr_en = 0, wr_index = 0, wr_data = 0, hazard = 0.
REQ-024 SHALL, during reset, drive mem_ready = 1 and alu_ready = 1 but accept nothing.
REQ-025 SHALL discard any FIFO contents and pending bits on reset asserted mid-operation, with no write issued after release.
REQ-026 SHALL accept requests on the first rising edge with rst_n = 1.

Verification
REQ-027 ALU only: alu_valid, rd=5, data 0x1234 at N -> wr_en=1, wr_index=5, wr_data=0x1234 at N+1.
REQ-028 Conflict: ALU rd=3 and mem index=7 data 0xBEEF both at N -> rd 3 written at N+1, index 7 written at N+2, fifo_count 1 at N+1 then 0.
REQ-029 Starvation: FIFO holding 1 entry, alu_valid held every cycle -> ALU wins 3 cycles, alu_ready=0 on the 4th, FIFO entry written next cycle, counter back to 0.
REQ-030 FIFO full: three back-to-back mem_valid while ALU continuous -> mem_ready=0 when fifo_count=2; the held third load is accepted only after a pop; all three written in order.
REQ-031 Scoreboard: issue rd=4, rs1_i=4 -> hazard=1 next cycle; ALU write rd=4 granted -> hazard=0 after that edge; same-cycle issue rd=4 and grant rd=4 -> hazard stays 1.
REQ-032 Reset: assert rst_n=0 with fifo_count=2 and pending nonzero -> all outputs at REQ-023 values immediately; no wr_en after release; alu_rd_i=0 request -> no write.
